// File: rtl/ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_ctrl_if
//   Request/response bus between a requester and ram_ctrl.
//   Requests: valid/ready handshake carrying write-enable, address and data.
//   Responses: valid/ready handshake carrying read data.
//
//   Signals
//     req_valid  requester -> ctrl   request present
//     req_ready  ctrl -> requester   request accepted when valid & ready
//     req_we     requester -> ctrl   1 = write, 0 = read
//     req_addr   requester -> ctrl   request address
//     req_wdata  requester -> ctrl   write data
//     rsp_valid  ctrl -> requester   read data available
//     rsp_ready  requester -> ctrl   consumer takes rsp_data when valid & ready
//     rsp_data   ctrl -> requester   read data, held while rsp_valid
//
//   Modports
//     master  requester side
//     slave   ram_ctrl side
// ---------------------------------------------------------------------------
interface ram_ctrl_if #(
  parameter int ADDRESS_BITS = 6,
  parameter int DATA_BITS    = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDRESS_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0]    req_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_BITS-1:0]    rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_ctrl.sv
// ---------------------------------------------------------------------------
// ram_ctrl
//   Front-end that owns the enable/address/data_in pins of a single-port ram
//   with a one-cycle registered read. Byte requests arrive on a valid/ready
//   bus; writes commit at the accepting edge (one per cycle), reads are
//   buffered into a held response (one per three cycles at full rsp_ready).
//
//   Optional feature (define RAM_CTRL_CLEAR_EN):
//     A CLEAR state sweeps every ram address to CLEAR_VALUE, one per cycle,
//     automatically after reset release and on each 'clear' pulse seen in
//     IDLE. Without the macro 'clear' is ignored and clear_busy is tied 0.
//
//   Parameters
//     ADDRESS_BITS  ram address width (must match the ram instance)
//     DATA_BITS     data width (must match the ram instance)
//     CLEAR_VALUE   word written by the clear sweep
//
//   Ports
//     clk           clock, all logic on posedge
//     rst_n         asynchronous active-low reset
//     bus           ram_ctrl_if.slave request/response bus
//     clear         one-cycle pulse: start clear sweep
//     clear_busy    clear sweep in progress
//     ram_enable    ram write strobe
//     ram_address   ram address
//     ram_data_in   ram write data
//     ram_data_out  ram read data (registered, 1-cycle latency)
// ---------------------------------------------------------------------------
module ram_ctrl #(
  parameter int                   ADDRESS_BITS = 6,
  parameter int                   DATA_BITS    = 8,
  parameter logic [DATA_BITS-1:0] CLEAR_VALUE  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ram_ctrl_if.slave               bus,
  input  logic                    clear,
  output logic                    clear_busy,
  output logic                    ram_enable,
  output logic [ADDRESS_BITS-1:0] ram_address,
  output logic [DATA_BITS-1:0]    ram_data_in,
  input  logic [DATA_BITS-1:0]    ram_data_out
);

  // RD    : ram is producing data for the address sampled at the accept edge
  // RSP   : response held until the consumer takes it
  // CLEAR : sweep in progress (feature build only)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RSP  = 2'd2
`ifdef RAM_CTRL_CLEAR_EN
    ,
    CLEAR = 2'd3
`endif
  } state_t;

`ifdef RAM_CTRL_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t               state_q;
  state_t               state_d;
  logic                 rsp_valid_q;
  logic [DATA_BITS-1:0] rsp_data_q;
  logic                 clear_req;

`ifdef RAM_CTRL_CLEAR_EN
  logic [ADDRESS_BITS-1:0] clr_cnt_q;

  // A pulse only matters in IDLE; elsewhere the FSM never looks at it.
  assign clear_req  = clear;
  assign clear_busy = (state_q == CLEAR);

  // Sweep address counter; wraps back to 0 on the final address so the
  // next sweep starts from the bottom without an explicit reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_q <= '0;
    end else if (state_q == CLEAR) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end
`else
  logic clear_unused;

  assign clear_req    = 1'b0;
  assign clear_busy   = 1'b0;
  assign clear_unused = clear | (|CLEAR_VALUE);
`endif

  // NOTE: the ram array lives outside this block and is never reset; only
  // the controller's own flops return to known values on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      if (state_q == RD) begin
        // ram_data_out now holds the word addressed at the accepting edge.
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= ram_data_out;
      end else if (state_q == RSP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_d       = state_q;
    bus.req_ready = 1'b0;
    ram_enable    = 1'b0;
    ram_address   = bus.req_addr;
    ram_data_in   = bus.req_wdata;

    unique case (state_q)
      IDLE: begin
        // A clear pulse beats a simultaneous request.
        bus.req_ready = ~clear_req;
`ifdef RAM_CTRL_CLEAR_EN
        if (clear_req) begin
          state_d = CLEAR;
        end else
`endif
        if (bus.req_valid) begin
          if (bus.req_we) begin
            ram_enable = 1'b1;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        state_d = RSP;
      end
      RSP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
`ifdef RAM_CTRL_CLEAR_EN
      CLEAR: begin
        ram_enable  = 1'b1;
        ram_address = clr_cnt_q;
        ram_data_in = CLEAR_VALUE;
        if (clr_cnt_q == '1) begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_ctrl
//   Scoreboard bench for ram_ctrl. A simple registered-read ram sits on the
//   ram pins. The stimulus thread keeps a plain array image of what the ram
//   should contain and pushes expected read data plus the edge on which the
//   response must appear; a monitor thread pops and compares whenever a
//   response is presented. Build with +define+RAM_CTRL_CLEAR_EN to exercise
//   the clear sweep.
// ---------------------------------------------------------------------------
module tb_ram_ctrl;
  localparam int         AW      = 6;
  localparam int         DW      = 8;
  localparam int         DEPTH   = 1 << AW;
  localparam logic [7:0] CLR_VAL = 8'hFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          clear_busy;
  logic          ram_enable;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out = '0;

  ram_ctrl_if #(.ADDRESS_BITS(AW), .DATA_BITS(DW)) bus ();

  ram_ctrl #(
    .ADDRESS_BITS(AW),
    .DATA_BITS   (DW),
    .CLEAR_VALUE (CLR_VAL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .clear       (clear),
    .clear_busy  (clear_busy),
    .ram_enable  (ram_enable),
    .ram_address (ram_address),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Stand-in for the ram: synchronous write, registered read.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_enable) ram_mem[ram_address] <= ram_data_in;
    ram_data_out <= ram_mem[ram_address];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference image and scoreboard.
  logic [DW-1:0] ref_mem [DEPTH];
  typedef struct {
    logic [DW-1:0] data;
    int unsigned   rise;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares every presented response against the queue head.
  bit seen = 0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      seen = 0;
    end else if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      end else begin
        if (!seen) begin
          check("rsp_latency", cyc, exp_q[0].rise);
          seen = 1;
        end
        check("rsp_data", {24'd0, bus.rsp_data}, {24'd0, exp_q[0].data});
        check("req_ready_in_rsp", {31'd0, bus.req_ready}, 32'd0);
        if (bus.rsp_ready) begin
          void'(exp_q.pop_front());
          seen = 0;
        end
      end
    end
  end

  // Random consumer back-pressure, enabled only during the random phase.
  bit rand_rdy = 0;
  always @(negedge clk) begin
    if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
  end

  // Issue one request; returns just after its accepting edge.
  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, output int unsigned acc);
    int waited = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    #1;
    while (!bus.req_ready && waited < 300) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("req_accept", {31'd0, bus.req_ready}, 32'd1);
    acc = cyc + 1;
    if (bus.req_ready) begin
      if (we) ref_mem[addr] = wdata;
      else    exp_q.push_back('{data: ref_mem[addr], rise: cyc + 2});
    end else begin
      bus.req_valid = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

`ifdef RAM_CTRL_CLEAR_EN
  // Call at a negedge while a sweep is (or is about to be) running.
  task automatic wait_sweep();
    int n = 0;
    #1;
    check("req_ready_in_clear", {31'd0, bus.req_ready}, 32'd0);
    while (clear_busy && n < 300) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("sweep_len", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = CLR_VAL;
  endtask
`endif

  initial begin
    int unsigned acc, prev, wacc;
    logic [DW-1:0] held;
    int guard;

    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
`ifdef RAM_CTRL_CLEAR_EN
    check("rst_clear_busy", {31'd0, clear_busy}, 32'd1);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
`else
    check("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
`endif
    @(negedge clk);
    rst_n = 1'b1;
`ifdef RAM_CTRL_CLEAR_EN
    wait_sweep();
`endif

    // 1: write then read same address on the next cycle.
    do_req(1'b1, 6'h03, 8'h5A, wacc);
    do_req(1'b0, 6'h03, 8'h00, acc);
    check("raw_back_to_back", acc, wacc + 1);
    #1;
    check("req_ready_in_rd", {31'd0, bus.req_ready}, 32'd0);
    go_idle();

    // 2: stalled response is held; consumption frees the controller.
    do_req(1'b1, 6'h10, 8'hC3, acc);
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 6'h10, 8'h00, acc);
    go_idle();
    @(posedge clk);
    held = ref_mem[6'h10];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("stall_rsp_hold", {24'd0, bus.rsp_data}, {24'd0, held});
      check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("consume_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("consume_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // 3: fill every address back to back, then read them all.
    for (int a = 0; a < DEPTH; a++) begin
      do_req(1'b1, AW'(a), DW'(a), acc);
      if (a > 0) check("write_rate", acc - prev, 1);
      prev = acc;
    end
    for (int a = 0; a < DEPTH; a++) begin
      do_req(1'b0, AW'(a), 8'h00, acc);
      if (a > 0) check("read_rate", acc - prev, 3);
      prev = acc;
    end
    go_idle();
    repeat (4) @(negedge clk);

    // 4: reset while a read is in RD discards it immediately.
    do_req(1'b0, 6'h07, 8'h00, acc);
    bus.req_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("abort_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`ifdef RAM_CTRL_CLEAR_EN
    wait_sweep();
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("no_stale_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end

`ifdef RAM_CTRL_CLEAR_EN
    // 5: swept contents read back; clear beats a concurrent request.
    do_req(1'b0, 6'h03, 8'h00, acc);
    do_req(1'b0, 6'h3F, 8'h00, acc);
    do_req(1'b1, 6'h05, 8'h11, acc);
    @(negedge clk);
    clear         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 6'h05;
    bus.req_wdata = 8'h22;
    #1;
    check("clear_blocks_req", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    clear         = 1'b0;
    bus.req_valid = 1'b0;
    wait_sweep();
    do_req(1'b0, 6'h05, 8'h00, acc);
    do_req(1'b0, 6'h00, 8'h00, acc);
    go_idle();
`else
    // 6: clear has no effect without the sweep feature.
    @(negedge clk);
    clear = 1'b1;
    #1;
    check("noclr_busy", {31'd0, clear_busy}, 32'd0);
    check("noclr_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("noclr_busy_after", {31'd0, clear_busy}, 32'd0);
    do_req(1'b0, 6'h2A, 8'h00, acc);
    go_idle();
`endif

    // Random mix with random consumer back-pressure.
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
             DW'($urandom), acc);
      if ($urandom_range(0, 4) == 0) go_idle();
    end
    go_idle();
    rand_rdy = 0;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
